jk_bank_sequencer: RTL and testbench

- Command-driven controller for a WIDTH-bit bank of JK master-slave flip-flops.
- Accepts one operation at a time over a valid/ready handshake and drives the bank's per-bit J/K inputs for one clock per step.
- Waits for the slave stage to settle, samples bank Q feedback, repeats for the requested step count, then reports the final value.
- Sits between the control logic and a JK register/counter bank, so that logic never hand-sequences J/K levels.

---
 rtl/jk_seq_pkg.sv | 20 ++
 rtl/jk_op_decode.sv | 54 +++++
 rtl/jk_bank_sequencer.sv | 115 +++++++++++
 tb/tb_jk_bank_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// Shared op codes, state encoding and widths for the JK bank sequencer.
package jk_seq_pkg;

  localparam int COUNT_W = 8;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_SET  = 3'd1;
  localparam logic [2:0] OP_CLR  = 3'd2;
  localparam logic [2:0] OP_TOG  = 3'd3;
  localparam logic [2:0] OP_LOAD = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/jk_op_decode.sv
// Combinational mapping from (op, mask, current Q) to per-bit J/K levels for one step.
module jk_op_decode
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  logic [WIDTH-1:0] t_inc;
  logic [WIDTH-1:0] t_dec;
  logic [WIDTH-1:0] d_shl;
  logic             inc_c;
  logic             dec_c;

  // Ripple toggle enables: a bit flips when every lower bit is 1 (INC) or 0 (DEC).
  always_comb begin
    inc_c = 1'b1;
    dec_c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_inc[i] = inc_c;
      t_dec[i] = dec_c;
      inc_c    = inc_c & q[i];
      dec_c    = dec_c & ~q[i];
    end
  end

  always_comb begin
    d_shl[0] = mask[0];
    for (int i = 1; i < WIDTH; i++) begin
      d_shl[i] = q[i-1];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    case (op)
      OP_SET:  j = mask;
      OP_CLR:  k = mask;
      OP_TOG:  begin j = mask;  k = mask;   end
      OP_LOAD: begin j = mask;  k = ~mask;  end
      OP_INC:  begin j = t_inc; k = t_inc;  end
      OP_DEC:  begin j = t_dec; k = t_dec;  end
      OP_SHL:  begin j = d_shl; k = ~d_shl; end
      default: begin j = '0;    k = '0;     end
    endcase
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Steps a JK master-slave bank through a latched command: drive, settle, sample, repeat.
//
// state   | meaning
// S_IDLE  | ready for a command, J=K=0
// S_DRIVE | J/K applied for one cycle; bank captures on the exit edge
// S_HOLD  | SETTLE_CYC cycles of J=K=0, Q_fb sampled on the last edge
// S_DONE  | one-cycle done pulse, then back to IDLE
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic               clk,
  input  logic               CLRN,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic [7:0]         cmd_count,
  output logic [WIDTH-1:0]   J,
  output logic [WIDTH-1:0]   K,
  input  logic [WIDTH-1:0]   Q_fb,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [2:0] HOLD_LAST = 3'(SETTLE_CYC - 1);

  logic [1:0]         state;
  logic [COUNT_W-1:0] remaining;
  logic [2:0]         hold_cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   data_q;

  logic [2:0]         dec_op;
  logic [WIDTH-1:0]   dec_mask;
  logic [WIDTH-1:0]   dec_j;
  logic [WIDTH-1:0]   dec_k;
  logic               xfer;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign xfer      = cmd_valid && cmd_ready;

  // The first step decodes straight from the command bus; later steps use the latched copy.
  assign dec_op   = cmd_ready ? cmd_op   : op_q;
  assign dec_mask = cmd_ready ? cmd_data : data_q;

  jk_op_decode #(.WIDTH(WIDTH)) u_decode (
    .op   (dec_op),
    .mask (dec_mask),
    .q    (Q_fb),
    .j    (dec_j),
    .k    (dec_k)
  );

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      state     <= S_IDLE;
      remaining <= '0;
      hold_cnt  <= '0;
      op_q      <= OP_NOP;
      data_q    <= '0;
      J         <= '0;
      K         <= '0;
      result    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          J <= '0;
          K <= '0;
          if (xfer) begin
            op_q      <= cmd_op;
            data_q    <= cmd_data;
            remaining <= (cmd_count == 8'd0) ? 8'd1 : cmd_count;
            J         <= dec_j;
            K         <= dec_k;
            state     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          J        <= '0;
          K        <= '0;
          hold_cnt <= HOLD_LAST;
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt == 3'd0) begin
            result    <= Q_fb;
            remaining <= remaining - 8'd1;
            // remaining is at least 1 here, so the decrement cannot wrap.
            if (remaining > 8'd1) begin
              J     <= dec_j;
              K     <= dec_k;
              state <= S_DRIVE;
            end else begin
              state <= S_DONE;
            end
          end else begin
            hold_cnt <= hold_cnt - 3'd1;
          end
        end
        default: begin
          J     <= '0;
          K     <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer with a behavioural JK bank closing the Q_fb loop.
module tb_jk_bank_sequencer;

  localparam logic [2:0] NOP = 3'd0, SET = 3'd1, CLR = 3'd2, TOG = 3'd3,
                         LOAD = 3'd4, INC = 3'd5, DEC = 3'd6, SHL = 3'd7;

  logic       clk = 1'b0;
  logic       CLRN;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_count;
  logic [3:0] J, K, Q_fb, result;
  logic       busy, done;

  logic [3:0] bank = 4'h0;
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] hold_q[$];

  typedef struct {
    logic [2:0] op;
    logic [3:0] data;
    logic [7:0] count;
    logic [3:0] exp_result;
    int         exp_lat;
  } vec_t;

  vec_t vecs[15];

  jk_bank_sequencer #(.WIDTH(4), .SETTLE_CYC(1)) dut (
    .clk       (clk),
    .CLRN      (CLRN),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .J         (J),
    .K         (K),
    .Q_fb      (Q_fb),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Master-slave JK bank: captures J/K on the rising edge.
  always @(posedge clk) bank <= (J & ~bank) | (~K & bank);
  assign Q_fb = bank;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one command; with scramble=1, cmd_valid stays high and the bus churns while busy.
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [3:0] data,
                         input logic [7:0] cnt, input logic [3:0] exp, input int exp_lat,
                         input bit scramble, input bit nop_chk);
    int k;
    bit got;
    int jk_bad;
    int busy_bad;
    logic [3:0] e;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      check({name, "_ready_timeout"}, 0, 1);
      return;
    end
    cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    if (!scramble) cmd_valid = 1'b0;
    hold_q.delete();
    jk_bad = 0; busy_bad = 0; got = 0; k = 1;
    while (!got && k <= 2000) begin
      if (!busy) busy_bad++;
      if (done) begin
        got = 1;
        cmd_valid = 1'b0;
        if (J != 4'h0 || K != 4'h0) jk_bad++;
      end else begin
        if (k % 2 == 0) begin
          hold_q.push_back(bank);
          if (J != 4'h0 || K != 4'h0) jk_bad++;
        end
        if (nop_chk && (J != 4'h0 || K != 4'h0)) jk_bad++;
        if (scramble) begin
          cmd_op = 3'($urandom); cmd_data = 4'($urandom); cmd_count = 8'($urandom);
        end
        @(posedge clk);
        #1;
        k++;
      end
    end
    if (!got) begin
      cmd_valid = 1'b0;
      check({name, "_done_timeout"}, 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_result"}, int'(result), int'(e));
    check({name, "_latency"}, k, exp_lat);
    check({name, "_jk_quiet"}, jk_bad, 0);
    check({name, "_busy"}, busy_bad, 0);
  endtask

  initial begin
    int dc;
    CLRN = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'h0; cmd_count = 8'd0;
    #3;
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_jk",    int'({J, K}), 0);
    check("rst_result", int'(result), 0);
    @(negedge clk); CLRN = 1'b1;

    // Reset in the middle of a 5-step INC: abandoned silently.
    @(negedge clk);
    cmd_op = INC; cmd_data = 4'h0; cmd_count = 8'd5; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    dc = done_cnt;
    repeat (3) @(posedge clk);
    #2; CLRN = 1'b0; #1;
    check("midrst_jk",    int'({J, K}), 0);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_busy",  int'(busy), 0);
    repeat (2) @(negedge clk);
    CLRN = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_done", done_cnt - dc, 0);
    run_cmd("rst_load", LOAD, 4'hA, 8'd1, 4'hA, 3, 1'b0, 1'b0);

    vecs[0]  = '{LOAD, 4'hE, 8'd1,   4'hE, 3};
    vecs[1]  = '{INC,  4'h0, 8'd3,   4'h1, 7};
    vecs[2]  = '{LOAD, 4'h0, 8'd1,   4'h0, 3};
    vecs[3]  = '{DEC,  4'h0, 8'd1,   4'hF, 3};
    vecs[4]  = '{TOG,  4'h5, 8'd1,   4'hA, 3};
    vecs[5]  = '{LOAD, 4'h0, 8'd1,   4'h0, 3};
    vecs[6]  = '{SHL,  4'h1, 8'd4,   4'hF, 9};
    vecs[7]  = '{LOAD, 4'h8, 8'd1,   4'h8, 3};
    vecs[8]  = '{SET,  4'h1, 8'd1,   4'h9, 3};
    vecs[9]  = '{CLR,  4'h8, 8'd1,   4'h1, 3};
    vecs[10] = '{NOP,  4'hF, 8'd2,   4'h1, 5};
    vecs[11] = '{INC,  4'h0, 8'd0,   4'h2, 3};
    vecs[12] = '{LOAD, 4'h0, 8'd1,   4'h0, 3};
    vecs[13] = '{INC,  4'h0, 8'd255, 4'hF, 511};
    vecs[14] = '{DEC,  4'h0, 8'd2,   4'hD, 5};

    for (int i = 0; i < 15; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].count,
              vecs[i].exp_result, vecs[i].exp_lat, 1'b0, vecs[i].op == NOP);
      if (i == 1) begin
        check("inc_seq_len", hold_q.size(), 3);
        if (hold_q.size() == 3) begin
          check("inc_seq0", int'(hold_q[0]), 4'hF);
          check("inc_seq1", int'(hold_q[1]), 4'h0);
          check("inc_seq2", int'(hold_q[2]), 4'h1);
        end
      end
    end

    // Bus churn while busy must not disturb the latched command or start a second one.
    run_cmd("hs_load", LOAD, 4'h3, 8'd1, 4'h3, 3, 1'b0, 1'b0);
    run_cmd("hs_inc0", INC, 4'h0, 8'd0, 4'h4, 3, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("hs_no_retrigger_busy", int'(busy), 0);
    check("hs_bank_stable", int'(bank), 4'h4);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
